// File: rtl/or1200_vlx_seq.sv
// VLX bit-packing sequencer: counts the valid bits held by the datapath
// accumulator and drains complete bytes through the store unit. When stuffing
// is enabled, a 0x00 is stored after every 0xFF. Handles flush padding, CPU
// stalls and ack timeouts.
module or1200_vlx_seq #(
    parameter int ACC_W       = 32,
    parameter int MAX_BITS    = 16,
    parameter bit STUFF_EN    = 1'b1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   set_bit_op_i,
    input  logic [4:0]             num_bits_i,
    input  logic                   flush_i,
    input  logic                   err_clr_i,
    input  logic [7:0]             top_byte_i,
    input  logic                   ack_i,
    output logic                   dp_shift_o,
    output logic                   dp_pad_o,
    output logic [2:0]             pad_bits_o,
    output logic                   dp_consume_o,
    output logic                   dp_clear_o,
    output logic                   store_req_o,
    output logic                   store_stuff_o,
    output logic                   stall_cpu_o,
    output logic [$clog2(ACC_W):0] bit_cnt_o,
    output logic                   err_o
);

    localparam int                CNT_W     = $clog2(ACC_W) + 1;
    localparam logic [4:0]        MAX_N     = 5'(MAX_BITS);
    localparam logic [7:0]        TMO_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  BYTE_BITS = CNT_W'(8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STORE = 2'd1,
        S_STUFF = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic [7:0]         tmo_q, tmo_d;
    logic               err_q, err_d;

    // Number of one-bits needed to round a partial byte up to a byte boundary.
    function automatic logic [2:0] pad_len(input logic [2:0] frac);
        return 3'd0 - frac;
    endfunction

    logic               busy;
    logic               op_legal;
    logic               op_take;
    logic               op_err;
    logic               flush_req;
    logic               flush_go;
    logic               pad_need;
    logic               tmo_hit;
    logic [2:0]         pad_w;
    logic [CNT_W-1:0]   op_sum;
    logic [CNT_W-1:0]   round_up;
    logic [CNT_W-1:0]   cnt_less_byte;

    assign busy          = (state_q != S_IDLE);
    assign op_legal      = (num_bits_i != 5'd0) && (num_bits_i <= MAX_N);
    assign op_take       = !busy && set_bit_op_i && op_legal;
    // Ops while draining are dropped; oversize ops are dropped everywhere.
    assign op_err        = set_bit_op_i && (busy || (num_bits_i > MAX_N));
    assign flush_req     = flush_i || flush_pend_q;
    // A same-cycle op wins; the flush waits in flush_pend for the next idle cycle.
    assign flush_go      = !busy && flush_req && !set_bit_op_i;
    assign pad_need      = (bit_cnt_q[2:0] != 3'd0);
    // The timeout fires on the last waiting cycle so that cycle still drives dp_clear.
    assign tmo_hit       = busy && !ack_i && (tmo_q == TMO_LAST);
    assign pad_w         = pad_len(bit_cnt_q[2:0]);
    assign op_sum        = bit_cnt_q + CNT_W'(num_bits_i);
    assign round_up      = bit_cnt_q + CNT_W'(pad_w);
    assign cnt_less_byte = bit_cnt_q - BYTE_BITS;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: enter STORE whenever a full byte is available, detour
    // through STUFF after a stored 0xFF, bail out to IDLE on ack timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (op_take && (op_sum >= BYTE_BITS)) begin
                    state_d = S_STORE;
                end else if (flush_go && (pad_need || (bit_cnt_q >= BYTE_BITS))) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (ack_i) begin
                    if (STUFF_EN && (top_byte_i == 8'hFF)) begin
                        state_d = S_STUFF;
                    end else if (cnt_less_byte >= BYTE_BITS) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_STUFF: begin
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (ack_i) begin
                    state_d = (bit_cnt_q >= BYTE_BITS) ? S_STORE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state and same-cycle inputs.
    always_comb begin
        dp_shift_o    = op_take;
        dp_pad_o      = flush_go && pad_need;
        pad_bits_o    = (flush_go && pad_need) ? pad_w : 3'd0;
        dp_consume_o  = (state_q == S_STORE) && ack_i;
        dp_clear_o    = tmo_hit;
        store_req_o   = busy;
        store_stuff_o = (state_q == S_STUFF);
        stall_cpu_o   = busy || flush_pend_q;
        bit_cnt_o     = bit_cnt_q;
        err_o         = err_q;
    end

    // Bit count, pending flush, ack timer and sticky error next values.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        flush_pend_d = flush_pend_q;
        tmo_d        = 8'd0;
        if (busy) begin
            if (flush_i) begin
                flush_pend_d = 1'b1;
            end
            if (!ack_i) begin
                tmo_d = tmo_q + 8'd1;
            end
            if ((state_q == S_STORE) && ack_i) begin
                bit_cnt_d = cnt_less_byte;
            end
        end else begin
            if (op_take) begin
                bit_cnt_d = op_sum;
            end else if (flush_go && pad_need) begin
                bit_cnt_d = round_up;
            end
            if (set_bit_op_i && flush_req) begin
                flush_pend_d = 1'b1;
            end else if (flush_go) begin
                flush_pend_d = 1'b0;
            end
        end
        if (tmo_hit) begin
            bit_cnt_d    = '0;
            flush_pend_d = 1'b0;
            tmo_d        = 8'd0;
        end
        // Setting has priority over a same-cycle clear.
        err_d = op_err || tmo_hit || (err_q && !err_clr_i);
    end

    // Bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bit_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            tmo_q        <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            flush_pend_q <= flush_pend_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_or1200_vlx_seq.sv
// Bench for or1200_vlx_seq: directed steps plus a random phase, each cycle
// compared against a bit-count / byte-drain model of the sequencer.
module tb_or1200_vlx_seq;

    localparam int ACC_W       = 32;
    localparam int MAX_BITS    = 16;
    localparam bit STUFF_EN    = 1'b1;
    localparam int ACK_TIMEOUT = 255;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       set_bit_op_i = 1'b0;
    logic [4:0] num_bits_i = 5'd0;
    logic       flush_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [7:0] top_byte_i = 8'd0;
    logic       ack_i = 1'b0;
    logic       dp_shift_o, dp_pad_o, dp_consume_o, dp_clear_o;
    logic [2:0] pad_bits_o;
    logic       store_req_o, store_stuff_o, stall_cpu_o, err_o;
    logic [5:0] bit_cnt_o;

    int checks = 0;
    int errors = 0;

    // Model: accumulated bits, owed stuff byte, pending flush, ack wait, error.
    int m_bits;
    int m_wait;
    bit m_stuff;
    bit m_fp;
    bit m_err;

    or1200_vlx_seq #(
        .ACC_W(ACC_W), .MAX_BITS(MAX_BITS), .STUFF_EN(STUFF_EN), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .set_bit_op_i(set_bit_op_i), .num_bits_i(num_bits_i),
        .flush_i(flush_i), .err_clr_i(err_clr_i), .top_byte_i(top_byte_i), .ack_i(ack_i),
        .dp_shift_o(dp_shift_o), .dp_pad_o(dp_pad_o), .pad_bits_o(pad_bits_o),
        .dp_consume_o(dp_consume_o), .dp_clear_o(dp_clear_o), .store_req_o(store_req_o),
        .store_stuff_o(store_stuff_o), .stall_cpu_o(stall_cpu_o), .bit_cnt_o(bit_cnt_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits = 0; m_wait = 0; m_stuff = 1'b0; m_fp = 1'b0; m_err = 1'b0;
    endtask

    // The sequencer is draining exactly when a whole byte or a stuff byte is owed.
    function automatic bit m_busy();
        return (m_bits >= 8) || m_stuff;
    endfunction

    task automatic check_outputs();
        bit busy;
        bit legal;
        bit e_pad;
        int frac;
        busy  = m_busy();
        legal = (num_bits_i != 5'd0) && (int'(num_bits_i) <= MAX_BITS);
        frac  = m_bits % 8;
        e_pad = !busy && !set_bit_op_i && (flush_i || m_fp) && (frac != 0);
        chk("dp_shift",    32'(dp_shift_o),    32'(!busy && set_bit_op_i && legal));
        chk("dp_pad",      32'(dp_pad_o),      32'(e_pad));
        chk("pad_bits",    32'(pad_bits_o),    32'(e_pad ? 8 - frac : 0));
        chk("dp_consume",  32'(dp_consume_o),  32'(busy && !m_stuff && ack_i));
        chk("dp_clear",    32'(dp_clear_o),    32'(busy && !ack_i && (m_wait == ACK_TIMEOUT - 1)));
        chk("store_req",   32'(store_req_o),   32'(busy));
        chk("store_stuff", 32'(store_stuff_o), 32'(m_stuff));
        chk("stall_cpu",   32'(stall_cpu_o),   32'(busy || m_fp));
        chk("bit_cnt",     32'(bit_cnt_o),     32'(m_bits));
        chk("err",         32'(err_o),         32'(m_err));
    endtask

    task automatic model_update();
        bit busy;
        bit set_err;
        bit tmo;
        int n;
        busy    = m_busy();
        set_err = 1'b0;
        tmo     = 1'b0;
        n       = int'(num_bits_i);
        if (!busy) begin
            m_wait = 0;
            if (set_bit_op_i) begin
                if (n > MAX_BITS) set_err = 1'b1;
                else m_bits += n;
                if (flush_i || m_fp) m_fp = 1'b1;
            end else if (flush_i || m_fp) begin
                if (m_bits % 8 != 0) m_bits = (m_bits / 8 + 1) * 8;
                m_fp = 1'b0;
            end
        end else begin
            if (set_bit_op_i) set_err = 1'b1;
            if (flush_i) m_fp = 1'b1;
            if (ack_i) begin
                m_wait = 0;
                if (m_stuff) begin
                    m_stuff = 1'b0;
                end else begin
                    m_bits -= 8;
                    if (STUFF_EN && top_byte_i == 8'hFF) m_stuff = 1'b1;
                end
            end else begin
                m_wait++;
                if (m_wait == ACK_TIMEOUT) begin
                    tmo = 1'b1; m_bits = 0; m_fp = 1'b0; m_stuff = 1'b0; m_wait = 0;
                end
            end
        end
        m_err = set_err || tmo || (m_err && !err_clr_i);
    endtask

    // One clock: drive inputs, check outputs before the edge, advance the model.
    task automatic step(input bit op, input int n, input bit fl, input bit ack,
                        input logic [7:0] top = 8'h00, input bit clr = 1'b0);
        set_bit_op_i = op;
        num_bits_i   = 5'(n);
        flush_i      = fl;
        ack_i        = ack;
        top_byte_i   = top;
        err_clr_i    = clr;
        #1;
        check_outputs();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        set_bit_op_i = 1'b0;
        num_bits_i   = 5'd0;
        flush_i      = 1'b0;
        ack_i        = 1'b0;
        top_byte_i   = 8'h00;
        err_clr_i    = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check_outputs();
        chk("reset_req", 32'(store_req_o), 32'd0);
        rst_i = 1'b1;

        // Simple 5+3 pack and single byte drain.
        step(1, 5, 0, 0);
        step(1, 3, 0, 0);
        chk("t1_cnt8", 32'(bit_cnt_o), 32'd8);
        chk("t1_req", 32'(store_req_o), 32'd1);
        chk("t1_stall", 32'(stall_cpu_o), 32'd1);
        step(0, 0, 0, 1, 8'h3C);
        chk("t1_cnt0", 32'(bit_cnt_o), 32'd0);
        chk("t1_unstall", 32'(stall_cpu_o), 32'd0);

        // 0xFF byte followed by a stuffed 0x00.
        step(1, 4, 0, 0);
        step(1, 4, 0, 0);
        step(0, 0, 0, 1, 8'hFF);
        chk("t2_stuff", 32'(store_stuff_o), 32'd1);
        chk("t2_req", 32'(store_req_o), 32'd1);
        step(0, 0, 0, 1, 8'h00);
        chk("t2_idle", 32'(store_req_o), 32'd0);

        // 7 + 16 bits: two stores with gaps between acks.
        step(1, 7, 0, 0);
        step(1, 16, 0, 0);
        chk("t3_cnt23", 32'(bit_cnt_o), 32'd23);
        step(0, 0, 0, 1, 8'h11);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t3_req_held", 32'(store_req_o), 32'd1);
        step(0, 0, 0, 1, 8'h22);
        chk("t3_cnt7", 32'(bit_cnt_o), 32'd7);
        chk("t3_idle", 32'(store_req_o), 32'd0);

        // Flush padding: 7 -> 8, then 3 -> 8 with five pad bits, then an empty flush.
        step(0, 0, 1, 0);
        step(0, 0, 0, 1, 8'h01);
        step(1, 3, 0, 0);
        step(0, 0, 1, 0);
        chk("t4_cnt8", 32'(bit_cnt_o), 32'd8);
        step(0, 0, 0, 1, 8'h02);
        step(0, 0, 1, 0);
        chk("t4_empty_cnt", 32'(bit_cnt_o), 32'd0);
        chk("t4_empty_stall", 32'(stall_cpu_o), 32'd0);

        // Op and flush in the same cycle: flush deferred one idle cycle.
        step(1, 3, 1, 0);
        chk("def_stall", 32'(stall_cpu_o), 32'd1);
        step(0, 0, 0, 0);
        chk("def_cnt8", 32'(bit_cnt_o), 32'd8);
        step(0, 0, 0, 1, 8'h5A);

        // Flush and an op arriving while draining.
        step(1, 8, 0, 0);
        step(0, 0, 1, 0);
        step(1, 4, 0, 0);
        chk("busy_op_err", 32'(err_o), 32'd1);
        step(0, 0, 0, 1, 8'h00);
        chk("busy_flush_pend", 32'(stall_cpu_o), 32'd1);
        step(0, 0, 0, 0);
        chk("busy_flush_done", 32'(stall_cpu_o), 32'd0);
        step(0, 0, 0, 0, 8'h00, 1'b1);
        chk("err_clr", 32'(err_o), 32'd0);

        // Ack timeout.
        step(1, 8, 0, 0);
        repeat (ACK_TIMEOUT - 1) step(0, 0, 0, 0);
        chk("t5_no_err_yet", 32'(err_o), 32'd0);
        step(0, 0, 0, 0);
        chk("t5_err", 32'(err_o), 32'd1);
        chk("t5_cnt0", 32'(bit_cnt_o), 32'd0);
        chk("t5_idle", 32'(store_req_o), 32'd0);
        step(0, 0, 0, 0, 8'h00, 1'b1);
        chk("t5_clr", 32'(err_o), 32'd0);
        step(1, 20, 0, 0);
        chk("t5_big_err", 32'(err_o), 32'd1);
        chk("t5_big_cnt", 32'(bit_cnt_o), 32'd0);
        step(1, 20, 0, 0, 8'h00, 1'b1);
        chk("t5_set_wins", 32'(err_o), 32'd1);
        step(0, 0, 0, 0, 8'h00, 1'b1);
        step(1, 0, 0, 0);
        chk("t5_zero_noerr", 32'(err_o), 32'd0);

        // Asynchronous reset in the middle of a store.
        step(1, 8, 0, 0);
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        chk("t6_req", 32'(store_req_o), 32'd0);
        chk("t6_stall", 32'(stall_cpu_o), 32'd0);
        chk("t6_cnt", 32'(bit_cnt_o), 32'd0);
        check_outputs();
        @(negedge clk_i);
        rst_i = 1'b1;
        step(1, 8, 0, 0);
        step(0, 0, 0, 1, 8'h77);
        chk("t6_drained", 32'(bit_cnt_o), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit         r_op;
            bit         r_fl;
            bit         r_ack;
            bit         r_clr;
            int         r_n;
            logic [7:0] r_top;
            r_op  = ($urandom_range(0, 3) == 0);
            r_n   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
            r_fl  = ($urandom_range(0, 9) == 0);
            r_ack = ($urandom_range(0, 2) == 0);
            r_clr = ($urandom_range(0, 15) == 0);
            r_top = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            step(r_op, r_n, r_fl, r_ack, r_top, r_clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
